// File: rtl/uart_tx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// uart_sched_pkg
// Shared types and elaboration-time helpers for the UART TX scheduler.
//   sched_state_e : scheduler FSM states
//   hold_cycles() : HOLD phase length in clock cycles
//   cnt_width()   : bits needed for a counter that reaches max_count-1
// ---------------------------------------------------------------------------
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } sched_state_e;

  // Data bits + parity + stop, plus the idle guard bits, each one bit period.
  function automatic int hold_cycles(input int d_width, input int clk_freq_mhz,
                                     input int guard_bits);
    return (d_width + 2 + guard_bits) * clk_freq_mhz;
  endfunction

  function automatic int cnt_width(input int max_count);
    int w;
    w = 1;
    while ((1 << w) < max_count) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: the winner is the first set bit of req
// at or after index ptr, wrapping modulo N_REQ.
//   req     : request vector
//   ptr     : highest-priority index this cycle (must be < N_REQ)
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : index of the granted request
//   any     : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic               found;
  int                 off;
  int                 sum;

  // Rotate so ptr lands on bit 0, pick the lowest set bit, rotate the index back.
  always_comb begin
    dbl   = {req, req};
    rot   = N_REQ'(dbl >> ptr);
    found = 1'b0;
    off   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    sum = off + int'(ptr);
    if (sum >= N_REQ) sum = sum - N_REQ;
    gnt_idx = IDX_W'(sum);
    gnt     = '0;
    if (found) gnt[gnt_idx] = 1'b1;
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART TX core among N_REQ requesters in round-robin order. The
// core has no busy flag, so frame occupancy is timed here from the bit period.
// New launches are deferred while rx_line shows receive activity (low).
//   clk, arst_n : clock, synchronous active-low reset
//   req_valid   : per-requester frame request
//   req_data    : per-requester payload, slice i = [i*D_WIDTH +: D_WIDTH]
//   req_ready   : one-cycle accept pulse (one-hot)
//   req_done    : one-cycle pulse on the last cycle of channel occupancy
//   rx_line     : UART RX line, monitored only
//   uart_start  : to core start, high for exactly one bit period
//   uart_data   : to core data_in, stable from accept+1 until end of HOLD
//   busy        : high in LAUNCH and HOLD
//   grant_id    : index of the current or last owner
// ---------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int D_WIDTH      = 8,
  parameter int CLK_FREQ_MHZ = 50,
  parameter int GUARD_BITS   = 1
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           req_done,
  input  logic                       rx_line,
  output logic                       uart_start,
  output logic [D_WIDTH-1:0]         uart_data,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IDX_W       = $clog2(N_REQ);
  localparam int BIT_CYCLES  = CLK_FREQ_MHZ;
  localparam int HOLD_CYCLES = hold_cycles(D_WIDTH, CLK_FREQ_MHZ, GUARD_BITS);
  localparam int CNT_W       = cnt_width(HOLD_CYCLES);

  localparam logic [CNT_W-1:0] LAUNCH_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_REQ - 1);

  sched_state_e        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_id_q, grant_id_d;
  logic [D_WIDTH-1:0]  data_q, data_d;

  logic [N_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    data_d     = data_q;
    req_ready  = '0;
    req_done   = '0;
    uart_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Low rx_line means a frame is arriving; hold off new launches.
        if (rx_line && arb_any) begin
          req_ready  = arb_gnt;
          data_d     = req_data[int'(arb_idx)*D_WIDTH +: D_WIDTH];
          grant_id_d = arb_idx;
          rr_ptr_d   = (arb_idx == IDX_LAST) ? '0 : arb_idx + IDX_W'(1);
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        // A full bit period guarantees the core sees exactly one tick with start high.
        uart_start = 1'b1;
        if (cnt_q == LAUNCH_LAST) begin
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          req_done[grant_id_q] = 1'b1;
          cnt_d                = '0;
          state_d              = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Handshake pulses are suppressed while reset is asserted.
    if (!arst_n) begin
      req_ready = '0;
      req_done  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      data_q     <= data_d;
    end
  end

  // Core computes parity combinationally from data_in, so drive the register directly.
  assign uart_data = data_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Self-checking bench: a table of directed vectors, a hand-written
// all-requesters sequence, and a randomized run, all compared each cycle
// against a frame-timing reference model.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int BIT  = 50;
  localparam int OCC  = 1 + BIT * (DW + 3 + 1);

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_done;
  logic            rx_line = 1'b1;
  logic            uart_start;
  logic [DW-1:0]   uart_data;
  logic            busy;
  logic [1:0]      grant_id;

  uart_tx_scheduler #(
    .N_REQ        (N),
    .D_WIDTH      (DW),
    .CLK_FREQ_MHZ (BIT),
    .GUARD_BITS   (1)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .req_done   (req_done),
    .rx_line    (rx_line),
    .uart_start (uart_start),
    .uart_data  (uart_data),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a frame occupies the channel from its accept cycle for OCC cycles.
  int         cyc      = 0;
  bit         m_active = 0;
  int         m_acc    = 0;
  int         m_ptr    = 0;
  int         m_owner  = 0;
  logic [7:0] m_data   = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [19:0] dut_outs();
    return {req_ready, req_done, uart_start, busy, grant_id, uart_data};
  endfunction

  task automatic step(input logic rn, input logic rx, input logic [3:0] v,
                      input logic [31:0] d);
    bit         in_frame;
    logic [3:0] e_rdy, e_done;
    logic       e_start;
    int         win;
    @(negedge clk);
    arst_n = rn; rx_line = rx; req_valid = v; req_data = d;
    #1;
    in_frame = m_active && (cyc > m_acc) && (cyc <= m_acc + OCC - 1);
    e_start  = m_active && (cyc >= m_acc + 1) && (cyc <= m_acc + BIT);
    e_done   = (m_active && cyc == m_acc + OCC - 1) ? (4'b0001 << m_owner) : 4'b0000;
    e_rdy    = '0;
    win      = -1;
    if (!in_frame && rx && (|v)) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (win < 0 && v[idx]) win = idx;
      end
      e_rdy = 4'b0001 << win;
    end
    if (rn)
      chk("model_outs", 32'(dut_outs()),
          32'({e_rdy, e_done, e_start, in_frame, 2'(m_owner), m_data}));
    if (!rn) begin
      m_active = 0; m_ptr = 0; m_owner = 0; m_data = '0;
    end else if (win >= 0) begin
      m_active = 1; m_acc = cyc; m_owner = win;
      m_data = d[win*8 +: 8];
      m_ptr = (win + 1) % N;
    end
    cyc++;
  endtask

  typedef struct {
    int         n;
    logic       rn;
    logic       rx;
    logic [3:0] v;
    logic [31:0] d;
    logic [3:0] e_rdy;
    logic [3:0] e_done;
    logic       e_start;
    logic       e_busy;
    logic [1:0] e_gid;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int acc_cyc[$];
    int acc_id[$];
    int rx_low;
    logic [3:0] rv;
    logic rn;

    //          n    rn    rx    v      d             rdy    done   st    busy  gid    data
    tbl[0]  = '{2,   1'b0, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{1,   1'b1, 1'b1, 4'h2, 32'h0000A500, 4'h2, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00};
    tbl[2]  = '{1,   1'b1, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 8'hA5};
    tbl[3]  = '{49,  1'b1, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 8'hA5};
    tbl[4]  = '{1,   1'b1, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 8'hA5};
    tbl[5]  = '{548, 1'b1, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 8'hA5};
    tbl[6]  = '{1,   1'b1, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h2, 1'b0, 1'b1, 2'd1, 8'hA5};
    tbl[7]  = '{1,   1'b1, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b0, 1'b0, 2'd1, 8'hA5};
    tbl[8]  = '{1,   1'b1, 1'b1, 4'h3, 32'h00002211, 4'h1, 4'h0, 1'b0, 1'b0, 2'd1, 8'hA5};
    tbl[9]  = '{1,   1'b1, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 8'h11};
    tbl[10] = '{599, 1'b1, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h1, 1'b0, 1'b1, 2'd0, 8'h11};
    tbl[11] = '{1,   1'b1, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h11};
    tbl[12] = '{200, 1'b1, 1'b0, 4'h1, 32'h00000033, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h11};
    tbl[13] = '{1,   1'b1, 1'b1, 4'h1, 32'h00000033, 4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 8'h11};
    tbl[14] = '{1,   1'b1, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 8'h33};
    tbl[15] = '{349, 1'b1, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 8'h33};
    tbl[16] = '{1,   1'b0, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 8'h33};
    tbl[17] = '{1,   1'b1, 1'b1, 4'h9, 32'h55000044, 4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00};
    tbl[18] = '{100, 1'b1, 1'b1, 4'h8, 32'h55000044, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 8'h44};
    tbl[19] = '{600, 1'b1, 1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h44};

    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        step(tbl[i].rn, tbl[i].rx, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d", i), 32'(dut_outs()),
          32'({tbl[i].e_rdy, tbl[i].e_done, tbl[i].e_start, tbl[i].e_busy,
               tbl[i].e_gid, tbl[i].e_data}));
    end

    // All requesters valid from reset: strict 0,1,2,3,0 order, one frame apart.
    step(1'b0, 1'b1, 4'h0, 32'h0);
    for (int i = 0; i < 4 * OCC + 6; i++) begin
      step(1'b1, 1'b1, 4'hF, $urandom);
      if (req_ready != 0) begin
        acc_cyc.push_back(cyc - 1);
        for (int j = 0; j < N; j++) if (req_ready[j]) acc_id.push_back(j);
      end
    end
    chk("all4_count", 32'(acc_cyc.size()), 32'd5);
    for (int i = 0; i < acc_cyc.size() && i < 5; i++) begin
      chk($sformatf("all4_id%0d", i), 32'(acc_id[i]), 32'(i % N));
      if (i > 0)
        chk($sformatf("all4_gap%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(OCC));
    end

    // Randomized traffic with RX bursts and occasional resets.
    rv = '0;
    rx_low = 0;
    for (int i = 0; i < 20000; i++) begin
      for (int j = 0; j < N; j++)
        if ($urandom_range(0, 39) == 0) rv[j] = ~rv[j];
      if (rx_low > 0) rx_low--;
      else if ($urandom_range(0, 299) == 0) rx_low = $urandom_range(1, 120);
      rn = ($urandom_range(0, 3999) != 0);
      step(rn, (rx_low == 0), rv, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmit channel among `N_REQ` requesters. It sits between the requesters and the UART core and drives the core's `start`/`data_in` pins with the timing the core requires. Because the core exposes no busy flag, the scheduler tracks frame occupancy itself from the bit-period arithmetic. It also defers new launches while the shared RX line shows receive activity.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `D_WIDTH`, 8: frame data width; must match the UART core
- `CLK_FREQ_MHZ`, 50: clock frequency in MHz; one bit period is `BIT_CYCLES = CLK_FREQ_MHZ` cycles (1 Mbps)
- `GUARD_BITS`, 1: idle bit periods appended after each frame before the next launch

- `clk`  in  1  system clock
- `arst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  N_REQ  per-requester frame request
- `req_data`  in  N_REQ*D_WIDTH  per-requester payload; slice i = `[i*D_WIDTH +: D_WIDTH]`
- `req_ready`  out  N_REQ  one-hot one-cycle accept pulse
- `req_done`  out  N_REQ  one-hot one-cycle pulse when the accepted frame's channel occupancy ends
- `rx_line`  in  1  UART RX line, monitored only
- `uart_start`  out  1  to UART core `start`
- `uart_data`  out  D_WIDTH  to UART core `data_in`
- `busy`  out  1  high in LAUNCH and HOLD
- `grant_id`  out  $clog2(N_REQ)  index of the current or last owner

## Operation
- States: IDLE, LAUNCH, HOLD.
- **IDLE**
  - Arbitration runs only when `rx_line==1` and `|req_valid`.
  - The winner is the first valid index at or after `rr_ptr`, wrapping modulo `N_REQ`.
  - Same cycle: pulse `req_ready[win]`, latch `req_data[win]` into `data_q`, set `grant_id<=win`, set `rr_ptr<=(win+1)%N_REQ`, go to LAUNCH.
- **LAUNCH**
  - `uart_start=1` for exactly `BIT_CYCLES` cycles. This guarantees the core samples exactly one bit-tick with start high.
  - Then go to HOLD.
- **HOLD**
  - `uart_start=0` for `(D_WIDTH+2+GUARD_BITS)*BIT_CYCLES` cycles.
  - On the last HOLD cycle, pulse `req_done[grant_id]`, then go to IDLE.
- `uart_data = data_q`, held stable from the cycle after accept through the end of HOLD, because the core computes TX parity combinationally from `data_in`.
- `rx_line==0` in IDLE blocks arbitration; pending requests wait. `rx_line` is ignored in LAUNCH and HOLD.
- `req_valid` deasserting while not granted is legal; that request is simply not picked. A requester must hold `req_data` stable only until its `req_ready` pulse.
- Single phase counter `cnt` (width covers the HOLD length); it reloads to 0 on every state change.

## Timing
- Reset values (cycle after `arst_n` sampled low): state IDLE, `cnt=0`, `rr_ptr=0`, `grant_id=0`, `data_q=0`, `uart_start=0`, `req_ready=0`, `req_done=0`, `busy=0`.
- Reset mid-frame aborts immediately: `uart_start` drops and no `req_done` is issued.
- Accept occurs in cycle T (IDLE). Then:
  - LAUNCH covers T+1..T+BIT_CYCLES.
  - HOLD follows for its full length.
  - `req_done` fires in the final HOLD cycle.
  - The next accept is at the earliest one cycle after `req_done`.
- Occupancy per frame is `1 + BIT_CYCLES*(D_WIDTH+3+GUARD_BITS)` cycles including the IDLE cycle. With defaults: 1 + 50*12 = 601.
- `busy` is high exactly in LAUNCH and HOLD.
- `req_ready` and `req_done` are never high in the same cycle for the same index.

## Structure
- Package `uart_sched_pkg`:
  - state enum `sched_state_e` {IDLE, LAUNCH, HOLD}
  - function `hold_cycles(D_WIDTH, CLK_FREQ_MHZ, GUARD_BITS)`
  - function `cnt_width` for counter sizing
- Sub-module `rr_arbiter`:
  - inputs `req`, `ptr`; outputs one-hot `gnt`, `gnt_idx`, `any`
  - purely combinational rotate-priority-rotate; `rr_ptr` stays in the top level.

## Test plan
- Single request: `req_valid=4'b0010`, data 8'hA5, defaults → `req_ready[1]` at T; `uart_start` high T+1..T+50; `uart_data=8'hA5` through HOLD; `req_done[1]` at T+600; `grant_id=1`.
- All four valid continuously from reset → grants in order 0,1,2,3,0; successive accept cycles exactly 601 cycles apart.
- `rr_ptr=2` after a grant to 1; then `req_valid=4'b0011` → grant 0 (wrap), not 1.
- `rx_line=0` while `req_valid=4'b0001` for 200 cycles → no `req_ready`; `rx_line` returns high → accept the same cycle.
- `arst_n` low for one cycle at HOLD cycle 300 → all outputs at reset values next cycle; no `req_done`; `rr_ptr=0`, so a fresh `req_valid=4'b1001` grants 0.
- `req_valid[3]` dropped during another requester's HOLD → no grant to 3; `req_ready` never pulses for a non-valid index.
